// File: rtl/data_consumer_pkg.sv
// Shared types and constants for the stream checker.
// Includes the state enum, LFSR geometry and the counter saturation helper.
package data_consumer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LFSR_W = 16;

  // Right-shift Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [31:0] NO_MISMATCH = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == NO_MISMATCH) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_consumer_bp_lfsr.sv
// Backpressure pseudo-random source for the stream checker.
// It reloads the seed on reset or load and shifts once per enabled cycle.
module bp_lfsr
  import data_consumer_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  logic w_fb;

  assign w_fb = ^(state & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= SEED;
    end else if (en) begin
      state <= {w_fb, state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/data_consumer.sv
// Compares a DUT stream with a golden stream under random backpressure.
// It counts beats and mismatches and aborts the test after a run of idle cycles.
module data_consumer
  import data_consumer_pkg::*;
#(
  parameter int          DATA_WIDTH     = 128,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] e_axis_tdata,
  input  logic                  e_axis_tvalid,
  input  logic                  e_axis_tlast,
  output logic                  e_axis_tready,
  input  logic [3:0]            stall_cfg,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [31:0]           beat_count,
  output logic [31:0]           mismatch_count,
  output logic [31:0]           first_mismatch_idx
);

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  state_e r_state;
  state_e w_state_nxt;

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_unused;
  logic              w_run;
  logic              w_arm;
  logic              w_stall;
  logic              w_xfer;
  logic              w_mis;
  logic              w_last;

  logic [31:0] r_tcnt;
  logic [31:0] r_bc;
  logic [31:0] r_mc;
  logic [31:0] r_idx;
  logic        r_to;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic [31:0] w_tcnt_nxt;
  logic [31:0] w_bc_nxt;
  logic [31:0] w_mc_nxt;
  logic [31:0] w_idx_nxt;
  logic        w_to_nxt;

  assign w_run    = (r_state == RUN);
  assign w_arm    = start && !w_run;
  assign w_stall  = (w_lfsr[3:0] < stall_cfg);
  assign w_unused = ^w_lfsr[LFSR_W-1:4];

  // Each ready waits on the other side's valid so both streams move together
  assign s_axis_tready = w_run && !w_stall && e_axis_tvalid;
  assign e_axis_tready = w_run && !w_stall && s_axis_tvalid;

  assign w_xfer = s_axis_tvalid && s_axis_tready;
  assign w_last = s_axis_tlast || e_axis_tlast;
  assign w_mis  = (s_axis_tdata != e_axis_tdata) ||
                  (s_axis_tlast != e_axis_tlast);

  bp_lfsr #(
    .SEED(LFSR_SEED)
  ) u_bp_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_arm),
    .en   (w_run),
    .state(w_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bc_nxt    = r_bc;
    w_mc_nxt    = r_mc;
    w_idx_nxt   = r_idx;
    w_to_nxt    = r_to;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_tcnt_nxt  = '0;
          w_bc_nxt    = '0;
          w_mc_nxt    = '0;
          w_idx_nxt   = NO_MISMATCH;
          w_to_nxt    = 1'b0;
        end
      end
      RUN: begin
        if (w_xfer) begin
          w_tcnt_nxt = '0;
          w_bc_nxt   = sat_inc(r_bc);
          if (w_mis) begin
            w_mc_nxt = sat_inc(r_mc);
            if (r_idx == NO_MISMATCH) w_idx_nxt = r_bc;
          end
          if (w_last) w_state_nxt = DONE;
        end else begin
          w_tcnt_nxt = sat_inc(r_tcnt);
          if (w_tcnt_nxt >= TO_LIM) begin
            w_to_nxt    = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bc    <= '0;
      r_mc    <= '0;
      r_idx   <= NO_MISMATCH;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bc    <= w_bc_nxt;
      r_mc    <= w_mc_nxt;
      r_idx   <= w_idx_nxt;
      r_to    <= w_to_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE);
      r_pass  <= (w_state_nxt == DONE) &&
                 (w_mc_nxt == 32'd0) && !w_to_nxt;
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign pass               = r_pass;
  assign timeout            = r_to;
  assign beat_count         = r_bc;
  assign mismatch_count     = r_mc;
  assign first_mismatch_idx = r_idx;

endmodule

// File: tb/tb_data_consumer.sv
// Directed bench for data_consumer with a cycle-level reference model.
// Model outputs are compared every cycle; literal expectations pin the model.
module tb_data_consumer;

  localparam int          DW   = 128;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          TO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] e_axis_tdata = '0;
  logic          e_axis_tvalid = 1'b0;
  logic          e_axis_tlast = 1'b0;
  logic          e_axis_tready;
  logic [3:0]    stall_cfg = 4'd0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [31:0]   beat_count;
  logic [31:0]   mismatch_count;
  logic [31:0]   first_mismatch_idx;

  always #5 clk = ~clk;

  data_consumer #(
    .DATA_WIDTH    (DW),
    .LFSR_SEED     (SEED),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .e_axis_tdata      (e_axis_tdata),
    .e_axis_tvalid     (e_axis_tvalid),
    .e_axis_tlast      (e_axis_tlast),
    .e_axis_tready     (e_axis_tready),
    .stall_cfg         (stall_cfg),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .timeout           (timeout),
    .beat_count        (beat_count),
    .mismatch_count    (mismatch_count),
    .first_mismatch_idx(first_mismatch_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done
  int          m_st = 0;
  logic [15:0] m_lfsr = SEED;
  int unsigned m_bc = 0, m_mc = 0, m_tc = 0;
  int unsigned m_idx = 32'hFFFF_FFFF;
  bit          m_to = 0;
  int          m_rc = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_stl, m_xf, m_mis;
  logic        rdy_hist[4];
  int          xq[$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_st = 0; m_lfsr = SEED; m_bc = 0; m_mc = 0;
      m_idx = 32'hFFFF_FFFF; m_to = 0; m_tc = 0;
    end else if (m_st == 1) begin
      m_stl = (m_lfsr[3:0] < stall_cfg);
      m_xf  = !m_stl && s_axis_tvalid && e_axis_tvalid;
      if (m_xf) begin
        m_mis = (s_axis_tdata != e_axis_tdata) ||
                (s_axis_tlast != e_axis_tlast);
        if (m_mis) begin
          if (m_idx == 32'hFFFF_FFFF) m_idx = m_bc;
          m_mc = sat(m_mc);
        end
        m_bc = sat(m_bc);
        m_tc = 0;
        if (s_axis_tlast || e_axis_tlast) m_st = 2;
      end else begin
        m_tc++;
        if (m_tc >= TO) begin m_to = 1; m_st = 2; end
      end
      m_lfsr = lfsr_next(m_lfsr);
      m_rc++;
    end else if (start) begin
      m_st = 1; m_lfsr = SEED; m_bc = 0; m_mc = 0;
      m_idx = 32'hFFFF_FFFF; m_to = 0; m_tc = 0; m_rc = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_stl = (m_lfsr[3:0] < stall_cfg);
      check("s_tready", 32'(s_axis_tready),
            32'(m_st == 1 && !m_stl && e_axis_tvalid));
      check("e_tready", 32'(e_axis_tready),
            32'(m_st == 1 && !m_stl && s_axis_tvalid));
      check("busy", 32'(busy), 32'(m_st == 1));
      check("done", 32'(done), 32'(m_st == 2));
      check("pass", 32'(pass), 32'(m_st == 2 && m_mc == 0 && !m_to));
      check("timeout", 32'(timeout), 32'(m_to));
      check("beat_count", beat_count, m_bc);
      check("mismatch_count", mismatch_count, m_mc);
      check("first_idx", first_mismatch_idx, m_idx);
      if (m_st == 1 && m_rc < 4) rdy_hist[m_rc] = s_axis_tready;
      if (s_axis_tvalid && s_axis_tready) xq.push_back(cyc);
    end
  end

  logic [DW-1:0] sd[16], ed[16];
  logic          sl[16], el[16];

  task automatic setup(input int sl_at, input int el_at);
    for (int i = 0; i < 16; i++) begin
      sd[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_5678 ^ 32'(i),
               64'h0BAD_F00D_0000_0000 | 64'(i * 3)};
      ed[i] = sd[i];
      sl[i] = (i == sl_at);
      el[i] = (i == el_at);
    end
  endtask

  task automatic drive(input int i);
    s_axis_tdata  = sd[i];
    e_axis_tdata  = ed[i];
    s_axis_tlast  = sl[i];
    e_axis_tlast  = el[i];
    s_axis_tvalid = 1'b1;
    e_axis_tvalid = 1'b1;
  endtask

  task automatic run_test(input int n);
    int cnt;
    start = 1'b1;
    drive(0);
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(i);
      cnt = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        cnt++;
        if (cnt > 200) begin
          checks++; errors++;
          $display("FAIL beat_wait: beat %0d got no ready, need ready", i);
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    e_axis_tvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_hist();
    check("hist0", 32'(rdy_hist[0]), 32'd0);
    check("hist1", 32'(rdy_hist[1]), 32'd0);
    check("hist2", 32'(rdy_hist[2]), 32'd1);
  endtask

  int t0, cnt;

  initial begin
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_bc", beat_count, 32'd0);
    check("rst_mc", mismatch_count, 32'd0);
    check("rst_idx", first_mismatch_idx, 32'hFFFF_FFFF);
    check("rst_flags", {28'd0, busy, done, pass, timeout}, 32'd0);
    @(posedge clk); #1;

    stall_cfg = 4'd0; setup(3, 3); xq.delete();
    run_test(4);
    @(negedge clk);
    check("t1_bc", beat_count, 32'd4);
    check("t1_mc", mismatch_count, 32'd0);
    check("t1_idx", first_mismatch_idx, 32'hFFFF_FFFF);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_nxfer", 32'(xq.size()), 32'd4);
    if (xq.size() == 4) check("t1_span", 32'(xq[3] - xq[0]), 32'd3);
    @(posedge clk); #1;

    stall_cfg = 4'd8; setup(15, 15);
    run_test(16);
    @(negedge clk);
    check_hist();
    check("t2_bc", beat_count, 32'd16);
    check("t2_pass", 32'(pass), 32'd1);
    @(posedge clk); #1;

    stall_cfg = 4'd0; setup(7, 7);
    sd[2][0] = ~sd[2][0];
    sd[5][0] = ~sd[5][0];
    run_test(8);
    @(negedge clk);
    check("t3_bc", beat_count, 32'd8);
    check("t3_mc", mismatch_count, 32'd2);
    check("t3_idx", first_mismatch_idx, 32'd2);
    check("t3_pass", 32'(pass), 32'd0);
    @(posedge clk); #1;

    setup(3, 5);
    run_test(4);
    @(negedge clk);
    check("t4_bc", beat_count, 32'd4);
    check("t4_mc", mismatch_count, 32'd1);
    check("t4_idx", first_mismatch_idx, 32'd3);
    check("t4_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      cnt++;
      if (cnt > 100) begin
        checks++; errors++;
        $display("FAIL t5_wait: done stayed low, need done");
        break;
      end
    end
    check("t5_lat", 32'(cyc - t0), 32'd16);
    check("t5_to", 32'(timeout), 32'd1);
    check("t5_pass", 32'(pass), 32'd0);
    @(posedge clk); #1;

    stall_cfg = 4'd8; setup(5, 5);
    run_test(3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_bc", beat_count, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    setup(3, 3);
    run_test(4);
    @(negedge clk);
    check_hist();
    check("t6_bc2", beat_count, 32'd4);
    check("t6_pass", 32'(pass), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1);
  end

endmodule

// File: doc/data_consumer.md
DATA_CONSUMER -- requirements
Module: data_consumer

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of the data under test and of the expected data.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, reset and start value of the backpressure LFSR; SHALL be nonzero.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, number of consecutive no-transfer cycles in RUN that abort the test.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_axis_tdata  input  DATA_WIDTH  data from the DUT (ciphertext stream).
REQ-007 s_axis_tvalid  input  1  DUT data valid.
REQ-008 s_axis_tlast  input  1  DUT last beat of the message.
REQ-009 s_axis_tready  output  1  consumer ready to the DUT.
REQ-010 e_axis_tdata  input  DATA_WIDTH  expected (golden) data.
REQ-011 e_axis_tvalid  input  1  expected data valid.
REQ-012 e_axis_tlast  input  1  expected last beat.
REQ-013 e_axis_tready  output  1  consumer ready to the golden source.
REQ-014 stall_cfg  input  4  backpressure density: 0 never stalls, 15 stalls 15/16 of cycles.
REQ-015 start  input  1  single-cycle pulse that arms a test.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  high in DONE.
REQ-018 pass  output  1  valid while done: no mismatches and no timeout.
REQ-019 timeout  output  1  test aborted by the timeout counter.
REQ-020 beat_count  output  32  beats compared in the current test.
REQ-021 mismatch_count  output  32  beats whose data or tlast differed.
REQ-022 first_mismatch_idx  output  32  0-based index of the first mismatching beat; 32'hFFFFFFFF if none.

Function
REQ-023 The FSM SHALL have states IDLE, RUN and DONE; start in IDLE or DONE SHALL go to RUN on the next cycle; start in RUN SHALL be ignored.
REQ-024 On entry to RUN, beat_count, mismatch_count, the timeout counter and timeout SHALL clear, first_mismatch_idx SHALL become all-ones, and the LFSR SHALL load LFSR_SEED.
REQ-025 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shift once per cycle in RUN, and hold otherwise.
REQ-026 stall SHALL be (lfsr[3:0] < stall_cfg); stall is therefore never asserted when stall_cfg is 0.
REQ-027 In RUN, s_axis_tready SHALL be !stall && e_axis_tvalid, and e_axis_tready SHALL be !stall && s_axis_tvalid; outside RUN both SHALL be 0.
REQ-028 A beat transfer SHALL occur when s_axis_tvalid && s_axis_tready; by construction both streams transfer together.
REQ-029 On a transfer, the beat SHALL be a mismatch if tdata differs or tlast differs.
REQ-030 On a transfer, beat_count SHALL increment; on a mismatch, mismatch_count SHALL increment and first_mismatch_idx SHALL take the pre-increment beat_count if it is still all-ones.
REQ-031 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-032 A transfer with s_axis_tlast or e_axis_tlast high SHALL move the FSM to DONE on the next cycle, with that beat counted.
REQ-033 The timeout counter SHALL increment on each RUN cycle without a transfer and clear on a transfer.
REQ-034 When the timeout counter reaches TIMEOUT_CYCLES, timeout SHALL set and the FSM SHALL go to DONE.
REQ-035 In DONE, the counters, timeout and pass SHALL hold until the next start.
REQ-036 pass SHALL be done && mismatch_count==0 && !timeout.
REQ-037 Status outputs SHALL be registered; counter updates SHALL be visible the cycle after the transfer.

Reset
REQ-038 On rst, the FSM SHALL enter IDLE and the LFSR SHALL load LFSR_SEED.
REQ-039 On rst, both treadys, busy, done, pass and timeout SHALL be 0, beat_count and mismatch_count 0, and first_mismatch_idx all-ones.
REQ-040 rst asserted mid-RUN SHALL abort the test with no further transfers from the next edge.

Structure
REQ-041 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the LFSR width (16), the tap mask, and the "no mismatch" constant 32'hFFFFFFFF.
REQ-042 The backpressure LFSR SHALL be one sub-module, named bp_lfsr, with ports clk, rst, load, en and the 16-bit state.

Verification
REQ-043 stall_cfg=0, 4 matching beats, tlast on beat 3 -> 4 transfers on consecutive cycles, beat_count=4, mismatch_count=0, pass=1, first_mismatch_idx=FFFFFFFF.
REQ-044 stall_cfg=8, 16 matching beats -> tready low exactly on cycles where lfsr[3:0]<8 (golden model), beat_count=16, pass=1.
REQ-045 8 beats, with beats 2 and 5 flipped in bit 0 -> mismatch_count=2, first_mismatch_idx=2, pass=0.
REQ-046 DUT tlast on beat 3, expected tlast on beat 5 -> DONE after beat 4 (index 3), mismatch_count=1, first_mismatch_idx=3.
REQ-047 TIMEOUT_CYCLES=16, s_axis_tvalid held low after start -> done with timeout=1 sixteen cycles after RUN entry, pass=0.
REQ-048 rst pulsed after beat 2 of 6, then start -> counters zero after rst, new test counts from 0, and the LFSR sequence restarts from LFSR_SEED.
